// File: rtl/core_run_pkg.sv
// core_run_pkg: shared FSM state encoding and width helper for the core run controller
package core_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/run_counter.sv
// run_counter: loadable up-counter with a terminal-count flag, shared by the reset and run phases
module run_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = count == limit;

    // restart from zero on load, otherwise count while enabled
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en)
            count <= count + W'(1);

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences a reset/run/halt cycle for a group of cores with timeout and abort
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 5,
    localparam int CNT_W     = clog2(RUN_CYCLES + 1)
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic [NUM_CORES-1:0] EnMask,
    input  logic [NUM_CORES-1:0] Halt,
    output logic [NUM_CORES-1:0] CoreReset,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Timeout,
    output logic [NUM_CORES-1:0] HaltMask,
    output logic [CNT_W-1:0]     CycleCount
);

    localparam int LIM_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int PW      = clog2(LIM_MAX);

    state_t               state;
    logic [NUM_CORES-1:0] en_lat;
    logic [NUM_CORES-1:0] hm_next;
    logic [PW-1:0]        ph_cnt;
    logic [PW-1:0]        ph_lim;
    logic                 ph_tc;
    logic                 ph_load;
    logic                 ph_en;
    logic                 accept;
    logic                 all_halted;

    // phase counter limit tracks the current phase; it restarts on entry to RESET and to RUN
    always_comb begin
        accept     = Start && (|EnMask) && (state == ST_IDLE || state == ST_DONE);
        ph_load    = accept || (state == ST_RESET && ph_tc);
        ph_en      = state == ST_RESET || state == ST_RUN;
        ph_lim     = (state == ST_RESET) ? PW'(RST_CYCLES - 1) : PW'(RUN_CYCLES - 1);
        hm_next    = HaltMask | (Halt & en_lat);
        all_halted = hm_next == en_lat;
    end

    run_counter #(
        .W(PW)
    ) u_cnt (
        .clk  (CLK),
        .rst_n(Reset_n),
        .load (ph_load),
        .en   (ph_en),
        .limit(ph_lim),
        .count(ph_cnt),
        .tc   (ph_tc)
    );

    // run sequencer; abort takes priority over start and over run completion
    always_ff @(posedge CLK or negedge Reset_n)
        if (!Reset_n) begin
            state      <= ST_IDLE;
            CoreReset  <= '1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            HaltMask   <= '0;
            CycleCount <= '0;
            en_lat     <= '0;
        end else if (Abort) begin
            state      <= ST_IDLE;
            CoreReset  <= '1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            HaltMask   <= '0;
            CycleCount <= '0;
            en_lat     <= '0;
        end else if (accept) begin
            state      <= ST_RESET;
            CoreReset  <= '1;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            HaltMask   <= '0;
            CycleCount <= '0;
            en_lat     <= EnMask;
        end else if (state == ST_RESET && ph_tc) begin
            state     <= ST_RUN;
            CoreReset <= ~en_lat;
        end else if (state == ST_RUN) begin
            CycleCount <= CycleCount + CNT_W'(1);
            HaltMask   <= hm_next;
            if (all_halted || ph_tc) begin
                state   <= ST_DONE;
                Busy    <= 1'b0;
                Done    <= all_halted;
                Timeout <= !all_halted;
            end
        end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed and randomized checks of core_run_ctrl against a run-level model
module tb_core_run_ctrl;

    localparam int RST = 2;
    localparam int RUN = 5;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [1:0] EnMask = 2'b00;
    logic [1:0] Halt = 2'b00;
    logic [1:0] CoreReset;
    logic       Busy;
    logic       Done;
    logic       Timeout;
    logic [1:0] HaltMask;
    logic [2:0] CycleCount;

    int checks = 0;
    int errors = 0;

    // model: active run, cycles since accepted start, finished-run flag and status
    bit         m_act, m_fin, m_done, m_to;
    int         m_t, m_cnt;
    logic [1:0] m_en, m_hm;

    core_run_ctrl #(
        .NUM_CORES (2),
        .RST_CYCLES(RST),
        .RUN_CYCLES(RUN)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Abort     (Abort),
        .EnMask    (EnMask),
        .Halt      (Halt),
        .CoreReset (CoreReset),
        .Busy      (Busy),
        .Done      (Done),
        .Timeout   (Timeout),
        .HaltMask  (HaltMask),
        .CycleCount(CycleCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = 0;
        m_fin  = 0;
        m_done = 0;
        m_to   = 0;
        m_t    = 0;
        m_cnt  = 0;
        m_en   = 2'b00;
        m_hm   = 2'b00;
    endtask

    task automatic model_step(input bit st, input bit ab, input logic [1:0] en, input logic [1:0] h);
        if (ab) begin
            model_reset();
        end else if (!m_act && st && en != 2'b00) begin
            m_act  = 1;
            m_fin  = 0;
            m_t    = 0;
            m_en   = en;
            m_hm   = 2'b00;
            m_cnt  = 0;
            m_done = 0;
            m_to   = 0;
        end else if (m_act) begin
            m_t++;
            if (m_t > RST) begin
                m_cnt = m_t - RST;
                m_hm  = m_hm | (h & m_en);
                if (m_hm == m_en) begin
                    m_done = 1;
                    m_act  = 0;
                    m_fin  = 1;
                end else if (m_cnt == RUN) begin
                    m_to  = 1;
                    m_act = 0;
                    m_fin = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_cr;
        exp_cr = ((m_act && m_t < RST) || (!m_act && !m_fin)) ? 2'b11 : ~m_en;
        chk("core_reset", CoreReset, exp_cr);
        chk("busy", Busy, m_act);
        chk("done", Done, m_done);
        chk("timeout", Timeout, m_to);
        chk("halt_mask", HaltMask, m_hm);
        chk("cycle_count", CycleCount, m_cnt);
    endtask

    task automatic cycle(input bit st, input bit ab, input logic [1:0] en, input logic [1:0] h);
        Start  = st;
        Abort  = ab;
        EnMask = en;
        Halt   = h;
        model_step(st, ab, en, h);
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 Reset_n = 1'b0;
        #2 check_all();
        @(negedge CLK) Reset_n = 1'b1;
        @(posedge CLK);
        #1;
        cycle(0, 0, 2'b00, 2'b11);

        // both cores, halts on run cycles 1 and 3
        cycle(1, 0, 2'b11, 2'b00);
        chk("r35_cr_rst1", CoreReset, 2'b11);
        cycle(0, 0, 2'b11, 2'b00);
        chk("r35_cr_rst2", CoreReset, 2'b11);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b01);
        cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b10);
        chk("r35_done", Done, 1);
        chk("r35_timeout", Timeout, 0);
        chk("r35_cnt", CycleCount, 3);
        chk("r35_hm", HaltMask, 2'b11);
        cycle(0, 0, 2'b00, 2'b11);

        // restart from DONE, core 1 disabled, never halts; Start while busy ignored
        cycle(1, 0, 2'b01, 2'b00);
        for (int i = 0; i < RST + RUN; i++) begin
            cycle(i == 3 || i == 5, 0, 2'b10, 2'b00);
            chk("r36_cr1", CoreReset[1], 1);
        end
        chk("r36_timeout", Timeout, 1);
        chk("r36_done", Done, 0);
        chk("r36_cnt", CycleCount, 5);

        // abort to IDLE, then Start with empty mask ignored
        cycle(0, 1, 2'b00, 2'b00);
        cycle(1, 0, 2'b00, 2'b00);
        chk("r38_busy", Busy, 0);
        chk("r38_cr", CoreReset, 2'b11);

        // last halt lands on the timeout cycle
        cycle(1, 0, 2'b11, 2'b00);
        for (int i = 0; i < RST; i++) cycle(0, 0, 2'b11, 2'b00);
        for (int k = 1; k <= RUN; k++) cycle(0, 0, 2'b11, k == 2 ? 2'b01 : (k == 5 ? 2'b10 : 2'b00));
        chk("r37_done", Done, 1);
        chk("r37_timeout", Timeout, 0);
        chk("r37_cnt", CycleCount, 5);

        // abort together with start in DONE
        cycle(1, 1, 2'b11, 2'b00);
        chk("r40_done", Done, 0);
        chk("r40_hm", HaltMask, 2'b00);
        chk("r40_cr", CoreReset, 2'b11);

        // async reset during run cycle 2, then a clean run
        cycle(1, 0, 2'b11, 2'b00);
        for (int i = 0; i < RST + 1; i++) cycle(0, 0, 2'b11, 2'b00);
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("r39_cr", CoreReset, 2'b11);
        @(negedge CLK) Reset_n = 1'b1;
        cycle(1, 0, 2'b11, 2'b00);
        for (int i = 0; i < RST + 1; i++) cycle(0, 0, 2'b11, 2'b00);
        cycle(0, 0, 2'b11, 2'b11);
        chk("r39_done", Done, 1);
        chk("r39_cnt", CycleCount, 2);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, 2'($urandom),
                  $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of controlled cores (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 2, cycles each core reset is held after Start (>=1).
REQ-003 SHALL have parameter RUN_CYCLES, default 5, maximum cycles in RUN before timeout (>=1).
REQ-004 SHALL have derived localparam CNT_W = clog2(RUN_CYCLES+1), minimum 1.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 Reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Start  input  1  one-cycle request to begin a run; sampled only in IDLE and DONE.
REQ-008 Abort  input  1  forces return to IDLE from any state.
REQ-009 EnMask  input  NUM_CORES  cores taking part in the run; sampled on accepted Start.
REQ-010 Halt  input  NUM_CORES  per-core halted indication, level.
REQ-011 CoreReset  output  NUM_CORES  per-core reset, active-high, registered.
REQ-012 Busy  output  1  high in RESET and RUN.
REQ-013 Done  output  1  run finished, all enabled cores halted.
REQ-014 Timeout  output  1  run finished on the RUN_CYCLES limit.
REQ-015 HaltMask  output  NUM_CORES  sticky per-core halted flags for the current run.
REQ-016 CycleCount  output  CNT_W  cycles spent in RUN; frozen in DONE.

Function
REQ-017 FSM states SHALL be IDLE, RESET, RUN, DONE.
REQ-018 IDLE: CoreReset all ones; Start with EnMask!=0 -> RESET next edge, latch EnMask, clear HaltMask, CycleCount, Done, Timeout; Start with EnMask==0 SHALL be ignored.
REQ-019 RESET: CoreReset all ones for exactly RST_CYCLES cycles, then -> RUN.
REQ-020 RUN: CoreReset[i] = ~EnMask_latched[i]; disabled cores stay in reset for the whole run.
REQ-021 RUN: CycleCount increments by 1 each cycle; HaltMask[i] set on any RUN cycle with Halt[i]=1 and core i enabled; never cleared until the next accepted Start.
REQ-022 RUN -> DONE with Done=1 on the edge where (HaltMask | Halt) & EnMask_latched equals EnMask_latched.
REQ-023 RUN -> DONE with Timeout=1 on the edge ending the RUN_CYCLES-th RUN cycle if REQ-022 is not satisfied; RUN SHALL never exceed RUN_CYCLES cycles.
REQ-024 Last halt and timeout on the same cycle: halt SHALL win (Done=1, Timeout=0).
REQ-025 Done and Timeout SHALL be mutually exclusive, and held in DONE.
REQ-026 DONE: CoreReset = ~EnMask_latched (halted cores remain released); Start (EnMask!=0) SHALL restart exactly as from IDLE.
REQ-027 Start while Busy SHALL be ignored.
REQ-028 Abort SHALL win over Start and halt/timeout in the same cycle; -> IDLE next edge, clearing Done, Timeout, HaltMask, CycleCount.
REQ-029 Halt inputs outside RUN SHALL be ignored.

Reset
REQ-030 Reset_n low SHALL immediately force state IDLE, CoreReset all ones, Busy=0, Done=0, Timeout=0, HaltMask=0, CycleCount=0, latched EnMask=0.
REQ-031 Reset mid-run SHALL abandon the run with no Done/Timeout pulse; release is synchronous to the first CLK edge after Reset_n rises.

Structure
REQ-032 FSM state encodings and the clog2 width function SHALL live in shared package core_run_pkg.
REQ-033 RESET-phase and RUN-phase counting SHALL use one sub-module, run_counter (loadable up-counter with terminal-count flag), instantiated once and reused across phases.
REQ-034 All outputs SHALL be driven from registers; no combinational input-to-output path.

Verification (NUM_CORES=2, RST_CYCLES=2, RUN_CYCLES=5)
REQ-035 Start, EnMask=2'b11, Halt=2'b01 at RUN cycle 1 and 2'b10 at RUN cycle 3 -> CoreReset=2'b11 for 2 cycles after Start, Done=1, Timeout=0, CycleCount=3, HaltMask=2'b11.
REQ-036 Start, EnMask=2'b01, Halt never set -> RUN lasts 5 cycles, Timeout=1, Done=0, CycleCount=5, CoreReset[1]=1 throughout.
REQ-037 EnMask=2'b11, Halt[0] at RUN cycle 2, Halt[1] at RUN cycle 5 -> Done=1, Timeout=0 (simultaneous rule).
REQ-038 Start repeated while Busy, and Start with EnMask=0 in IDLE -> no state change, no status change.
REQ-039 Reset_n low during RUN cycle 2, then Start -> all outputs at reset values immediately; next run completes normally from CycleCount=0.
REQ-040 Abort asserted with Start in DONE -> IDLE, Done=0, Timeout=0, HaltMask=0, CoreReset=2'b11.
